// File: rtl/alu_seq_ctrl_if.sv
// Bundle of the host request/response signals and the external ALU bus
// for alu_seq_ctrl.
interface alu_seq_ctrl_if;
    // Request handshake: a request is taken on the rising edge where start=1
    // and ready=1. done pulses once per accepted request. result and flags
    // are valid from that pulse until the next one.
    logic        start;
    logic [4:0]  opcode;
    logic [7:0]  a_lo;
    logic [7:0]  a_hi;
    logic [7:0]  b_lo;
    logic [7:0]  b_hi;
    logic        ready;
    logic        done;
    logic [15:0] result;
    logic [7:0]  flags;

    // ALU bus: the operands go out, and the ALU answers in the same cycle.
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [4:0]  alu_oper;
    logic        alu_cin;
    logic [7:0]  alu_r;
    logic        alu_carry;
    logic        alu_ovf;

    modport slave (
        input  start, opcode, a_lo, a_hi, b_lo, b_hi,
        input  alu_r, alu_carry, alu_ovf,
        output ready, done, result, flags,
        output alu_a, alu_b, alu_oper, alu_cin
    );

    modport master (
        output start, opcode, a_lo, a_hi, b_lo, b_hi,
        output alu_r, alu_carry, alu_ovf,
        input  ready, done, result, flags,
        input  alu_a, alu_b, alu_oper, alu_cin
    );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Sequences 8-bit and 16-bit add/sub operations over an external 8-bit ALU.
// A 16-bit operation takes one ALU pass per byte.
module alu_seq_ctrl (
    input  logic          clk,
    input  logic          rst,
    alu_seq_ctrl_if.slave bus,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [4:0]  op_q;
    logic [7:0]  a_lo_q, a_hi_q, b_lo_q, b_hi_q;
    logic [7:0]  res_lo_q;
    logic        c_lo_q;
    logic [15:0] result_q;
    logic [7:0]  flags_q;

    logic        is16;
    logic        is_pass;
    logic [15:0] res8_val, res16_val;
    logic [7:0]  flags8_val, flags16_val;

    assign is16    = (op_q[4:1] == 4'b0001);
    assign is_pass = |op_q[4:2];

    // The flags cover the final pass. Zero and parity span the full
    // effective width.
    always_comb begin
        res8_val    = {8'h00, bus.alu_r};
        res16_val   = {bus.alu_r, res_lo_q};
        flags8_val  = {3'b000, bus.alu_ovf & ~is_pass, ~^bus.alu_r,
                       (bus.alu_r == 8'h00), bus.alu_r[7], bus.alu_carry};
        flags16_val = {3'b000, bus.alu_ovf, ~^res16_val,
                       (res16_val == 16'h0000), bus.alu_r[7], bus.alu_carry};
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = LO;
            LO:      state_nxt = is16 ? HI : DONE;
            HI:      state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus.ready    = 1'b0;
        bus.done     = 1'b0;
        bus.alu_a    = 8'h00;
        bus.alu_b    = 8'h00;
        bus.alu_oper = 5'b00000;
        bus.alu_cin  = 1'b0;
        case (state)
            IDLE: bus.ready = 1'b1;
            LO: begin
                bus.alu_a    = a_lo_q;
                bus.alu_b    = b_lo_q;
                bus.alu_oper = is16 ? {4'b0000, op_q[0]} : op_q;
            end
            HI: begin
                bus.alu_a    = a_hi_q;
                bus.alu_b    = b_hi_q;
                bus.alu_cin  = c_lo_q;
                bus.alu_oper = {4'b0000, op_q[0]};
            end
            DONE:    bus.done = 1'b1;
            default: bus.ready = 1'b0;
        endcase
    end

    // Operand capture, the low-pass registers and the published result.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= 5'b00000;
            a_lo_q   <= 8'h00;
            a_hi_q   <= 8'h00;
            b_lo_q   <= 8'h00;
            b_hi_q   <= 8'h00;
            res_lo_q <= 8'h00;
            c_lo_q   <= 1'b0;
            result_q <= 16'h0000;
            flags_q  <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_q   <= bus.opcode;
                        a_lo_q <= bus.a_lo;
                        a_hi_q <= bus.a_hi;
                        b_lo_q <= bus.b_lo;
                        b_hi_q <= bus.b_hi;
                    end
                end
                LO: begin
                    res_lo_q <= bus.alu_r;
                    c_lo_q   <= bus.alu_carry;
                    if (!is16) begin
                        result_q <= res8_val;
                        flags_q  <= flags8_val;
                    end
                end
                HI: begin
                    result_q <= res16_val;
                    flags_q  <= flags16_val;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.result = result_q;
    assign bus.flags  = flags_q;
    assign dbg_state  = state;

endmodule
